// File: rtl/store_buffer_pkg.sv
// Shared sizing, tag/pointer types and the entry record for the store buffer.
package store_buffer_pkg;

    localparam int DEPTH = 8;
    localparam int TW    = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef logic [TW-1:0] sb_tag_t;
    typedef logic [TW:0]   sb_ptr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    // Distance from older pointer b to younger pointer a; the wrap bit keeps full distinct from empty.
    function automatic sb_ptr_t ptr_dist(input sb_ptr_t a, input sb_ptr_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/store_fwd_match.sv
// Youngest-first address match over the live window of store buffer slots.
module store_fwd_match
    import store_buffer_pkg::*;
(
    input  sb_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  sb_tag_t          start,
    input  logic [AW-1:0]    load_addr,
    output logic             hit,
    output logic [DW-1:0]    data
);

    // Walk from oldest (start) to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin : age_walk
            sb_tag_t idx;
            idx = start + sb_tag_t'(i);
            if (valid[idx] && (entries[idx].addr == load_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: allocate, commit, drain to memory, with store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            kill,
    input  logic            en,
    input  logic [AW+DW-1:0] unit2buf,
    output sb_tag_t         free_entry,
    output logic            full,
    input  logic            commit,
    input  sb_tag_t         commit_entry,
    output logic            commit_err,
    input  logic [AW-1:0]   load_addr,
    output logic            fwd_hit,
    output logic [DW-1:0]   fwd_data,
    output logic            is_storing,
    output logic [AW-1:0]   store_addr,
    output logic [DW-1:0]   store_data,
    input  logic            mem_ready
);

    localparam sb_ptr_t PTR_ONE   = sb_ptr_t'(1);
    localparam sb_ptr_t PTR_DEPTH = sb_ptr_t'(DEPTH);

    sb_ptr_t          head;
    sb_ptr_t          cmt;
    sb_ptr_t          tail;
    sb_ptr_t          count;
    sb_ptr_t          cmt_next;
    sb_entry_t        slots [DEPTH];
    sb_entry_t        wr_entry;
    logic [DEPTH-1:0] valid;
    logic             do_alloc;
    logic             do_commit;
    logic             do_drain;

    assign count      = ptr_dist(tail, head);
    assign full       = (count == PTR_DEPTH);
    assign free_entry = tail[TW-1:0];

    assign wr_entry.addr = unit2buf[AW+DW-1:DW];
    assign wr_entry.data = unit2buf[DW-1:0];

    // Entry allocated this cycle is not yet visible to the commit check (uses registered tail).
    assign do_alloc  = en && !full && !kill;
    assign do_commit = commit && (cmt != tail) && (commit_entry == cmt[TW-1:0]);
    assign do_drain  = is_storing && mem_ready;
    assign cmt_next  = do_commit ? (cmt + PTR_ONE) : cmt;

    assign is_storing = (head != cmt);
    assign store_addr = slots[head[TW-1:0]].addr;
    assign store_data = slots[head[TW-1:0]].data;

    // Control state: the three pointers and the sticky commit error.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            cmt        <= '0;
            tail       <= '0;
            commit_err <= 1'b0;
        end else begin
            if (do_drain) begin
                head <= head + PTR_ONE;
            end
            cmt <= cmt_next;
            if (commit && !do_commit) begin
                commit_err <= 1'b1;
            end
            if (kill) begin
                tail <= cmt_next;
            end else if (do_alloc) begin
                tail <= tail + PTR_ONE;
            end
        end
    end

    // Slot storage carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            slots[tail[TW-1:0]] <= wr_entry;
        end
    end

    always_comb begin
        valid = '0;
        for (int s = 0; s < DEPTH; s++) begin : live_mask
            sb_tag_t offs;
            offs     = sb_tag_t'(s) - head[TW-1:0];
            valid[s] = ({1'b0, offs} < count);
        end
    end

    store_fwd_match u_fwd (
        .entries   (slots),
        .valid     (valid),
        .start     (head[TW-1:0]),
        .load_addr (load_addr),
        .hit       (fwd_hit),
        .data      (fwd_data)
    );

    property p_count_bounded;
        @(posedge clk) disable iff (reset) count <= PTR_DEPTH;
    endproperty
    assert property (p_count_bounded);

    property p_cmt_in_window;
        @(posedge clk) disable iff (reset) ptr_dist(cmt, head) <= count;
    endproperty
    assert property (p_cmt_in_window);

endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer: table of per-cycle stimulus/expectations plus corner sequences.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            kill;
    logic            en;
    logic [AW+DW-1:0] unit2buf;
    sb_tag_t         free_entry;
    logic            full;
    logic            commit;
    sb_tag_t         commit_entry;
    logic            commit_err;
    logic [AW-1:0]   load_addr;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;
    logic            is_storing;
    logic [AW-1:0]   store_addr;
    logic [DW-1:0]   store_data;
    logic            mem_ready;

    int checks = 0;
    int errors = 0;

    store_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .kill         (kill),
        .en           (en),
        .unit2buf     (unit2buf),
        .free_entry   (free_entry),
        .full         (full),
        .commit       (commit),
        .commit_entry (commit_entry),
        .commit_err   (commit_err),
        .load_addr    (load_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .is_storing   (is_storing),
        .store_addr   (store_addr),
        .store_data   (store_data),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        kl;
        logic        al;
        logic [31:0] a;
        logic [31:0] d;
        logic        cm;
        logic [2:0]  ce;
        logic        mr;
        logic [31:0] la;
        logic        x_full;
        logic [2:0]  x_fe;
        logic        x_st;
        logic [31:0] x_sa;
        logic [31:0] x_sd;
        logic        x_hit;
        logic [31:0] x_fd;
        logic        x_err;
    } vec_t;

    function automatic vec_t v(
        input logic rst, input logic kl, input logic al, input logic [31:0] a, input logic [31:0] d,
        input logic cm, input logic [2:0] ce, input logic mr, input logic [31:0] la,
        input logic x_full, input logic [2:0] x_fe, input logic x_st, input logic [31:0] x_sa,
        input logic [31:0] x_sd, input logic x_hit, input logic [31:0] x_fd, input logic x_err);
        vec_t t;
        t.rst = rst; t.kl = kl; t.al = al; t.a = a; t.d = d; t.cm = cm; t.ce = ce; t.mr = mr; t.la = la;
        t.x_full = x_full; t.x_fe = x_fe; t.x_st = x_st; t.x_sa = x_sa; t.x_sd = x_sd;
        t.x_hit = x_hit; t.x_fd = x_fd; t.x_err = x_err;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and let the clock edge take it.
    task automatic apply(input vec_t t);
        reset        = t.rst;
        kill         = t.kl;
        en           = t.al;
        unit2buf     = {t.a, t.d};
        commit       = t.cm;
        commit_entry = t.ce;
        mem_ready    = t.mr;
        load_addr    = t.la;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input vec_t t, input string tag, input int idx);
        check($sformatf("%s[%0d] full", tag, idx), 64'(full), 64'(t.x_full));
        check($sformatf("%s[%0d] free_entry", tag, idx), 64'(free_entry), 64'(t.x_fe));
        check($sformatf("%s[%0d] is_storing", tag, idx), 64'(is_storing), 64'(t.x_st));
        if (t.x_st) begin
            check($sformatf("%s[%0d] store_addr", tag, idx), 64'(store_addr), 64'(t.x_sa));
            check($sformatf("%s[%0d] store_data", tag, idx), 64'(store_data), 64'(t.x_sd));
        end
        check($sformatf("%s[%0d] fwd_hit", tag, idx), 64'(fwd_hit), 64'(t.x_hit));
        check($sformatf("%s[%0d] fwd_data", tag, idx), 64'(fwd_data), 64'(t.x_fd));
        check($sformatf("%s[%0d] commit_err", tag, idx), 64'(commit_err), 64'(t.x_err));
    endtask

    task automatic run(input vec_t t, input string tag, input int idx);
        apply(t);
        check_vec(t, tag, idx);
    endtask

    vec_t tbl[$];

    initial begin
        int cyc;
        reset = 1'b1; kill = 1'b0; en = 1'b0; unit2buf = '0; commit = 1'b0;
        commit_entry = '0; mem_ready = 1'b0; load_addr = '0;

        //              rst kl al a       d      cm ce mr la      | full fe st sa      sd     hit fd     err
        tbl.push_back(v(1, 0, 0, 0,      0,     0, 0, 0, 0,       0, 0, 0, 0,      0,     0, 0,     0));
        tbl.push_back(v(0, 0, 0, 0,      0,     0, 0, 0, 'h100,   0, 0, 0, 0,      0,     0, 0,     0));
        tbl.push_back(v(0, 0, 1, 'h100,  'hA,   0, 0, 0, 'h100,   0, 1, 0, 0,      0,     1, 'hA,   0));
        tbl.push_back(v(0, 0, 1, 'h104,  'hB,   0, 0, 0, 'h104,   0, 2, 0, 0,      0,     1, 'hB,   0));
        tbl.push_back(v(0, 0, 1, 'h108,  'hC,   1, 0, 0, 'h100,   0, 3, 1, 'h100,  'hA,   1, 'hA,   0));
        tbl.push_back(v(0, 0, 0, 0,      0,     1, 1, 0, 'h108,   0, 3, 1, 'h100,  'hA,   1, 'hC,   0));
        tbl.push_back(v(0, 0, 0, 0,      0,     0, 0, 1, 'h100,   0, 3, 1, 'h104,  'hB,   0, 0,     0));
        tbl.push_back(v(0, 0, 0, 0,      0,     0, 0, 1, 'h108,   0, 3, 0, 0,      0,     1, 'hC,   0));
        tbl.push_back(v(0, 0, 0, 0,      0,     0, 0, 0, 'h104,   0, 3, 0, 0,      0,     0, 0,     0));
        tbl.push_back(v(1, 0, 0, 0,      0,     0, 0, 0, 0,       0, 0, 0, 0,      0,     0, 0,     0));
        tbl.push_back(v(0, 0, 1, 'h400,  1,     0, 0, 0, 'h400,   0, 1, 0, 0,      0,     1, 1,     0));
        tbl.push_back(v(0, 0, 1, 'h404,  2,     0, 0, 0, 'h404,   0, 2, 0, 0,      0,     1, 2,     0));
        tbl.push_back(v(0, 0, 1, 'h408,  3,     0, 0, 0, 'h408,   0, 3, 0, 0,      0,     1, 3,     0));
        tbl.push_back(v(0, 0, 1, 'h40C,  4,     0, 0, 0, 'h40C,   0, 4, 0, 0,      0,     1, 4,     0));
        tbl.push_back(v(0, 1, 1, 'h500,  5,     1, 0, 0, 'h404,   0, 1, 1, 'h400,  1,     0, 0,     0));
        tbl.push_back(v(0, 0, 0, 0,      0,     0, 0, 1, 'h500,   0, 1, 0, 0,      0,     0, 0,     0));
        tbl.push_back(v(0, 0, 0, 0,      0,     0, 0, 0, 'h400,   0, 1, 0, 0,      0,     0, 0,     0));

        foreach (tbl[i]) run(tbl[i], "tbl", i);

        // Fill to full, reject while full, drain one, allocate into the wrapped slot.
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < DEPTH; i++)
            apply(v(0, 0, 1, 'h600 + 4 * i, 'h10 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(v(0, 0, 1, 'h200, 'hDEAD, 0, 0, 0, 'h200,  1, 0, 0, 0, 0, 0, 0, 0), "full", 0);
        run(v(0, 0, 0, 0, 0, 1, 0, 0, 'h61C,           1, 0, 1, 'h600, 'h10, 1, 'h17, 0), "full", 1);
        run(v(0, 0, 1, 'h208, 'hEE, 0, 0, 1, 'h208,    0, 0, 0, 0, 0, 0, 0, 0), "full", 2);
        run(v(0, 0, 1, 'h20C, 'h5, 0, 0, 0, 'h20C,     1, 1, 0, 0, 0, 1, 'h5, 0), "full", 3);

        // Same-address stores: youngest wins, first without and then across the wrap.
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(v(0, 0, 1, 'h300, 1, 0, 0, 0, 'h300, 0, 1, 0, 0, 0, 1, 1, 0), "fwd", 0);
        run(v(0, 0, 1, 'h300, 2, 0, 0, 0, 'h300, 0, 2, 0, 0, 0, 1, 2, 0), "fwd", 1);
        for (int i = 2; i < 7; i++)
            apply(v(0, 0, 1, 'h700 + 4 * i, i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            apply(v(0, 0, 0, 0, 0, 1, 3'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (is_storing && cyc < 20) begin
            apply(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            cyc++;
        end
        check("drain bound", 64'(cyc < 20), 64'(1));
        run(v(0, 0, 0, 0, 0, 0, 0, 0, 'h300, 0, 7, 0, 0, 0, 0, 0, 0), "fwd", 2);
        run(v(0, 0, 1, 'h300, 1, 0, 0, 0, 'h300, 0, 0, 0, 0, 0, 1, 1, 0), "fwd", 3);
        run(v(0, 0, 1, 'h300, 2, 0, 0, 0, 'h300, 0, 1, 0, 0, 0, 1, 2, 0), "fwd", 4);

        // Commit tag mismatch sets a sticky error that only reset clears.
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(v(0, 0, 1, 'h900, 9, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0), "err", 0);
        run(v(0, 0, 0, 0, 0, 1, 3, 0, 0,         0, 1, 0, 0, 0, 0, 0, 1), "err", 1);
        run(v(0, 0, 0, 0, 0, 1, 0, 0, 'h900,     0, 1, 1, 'h900, 9, 1, 9, 1), "err", 2);
        run(v(1, 0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0), "err", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
